// File: rtl/game_status_checker.sv
// Sequential win/tie detector for a 3x3 board.
// Snapshots the board on a check pulse and scans the eight winning lines, one per clock.
// Results are sticky until newGame.
//
// Parameters:
//   EARLY_EXIT  1: stop at the first winning line; 0: always scan all 8 lines.
//
// Ports:
//   ph1          system clock, rising edge
//   reset        asynchronous active-low reset
//   gBoard       board, cell i = gBoard[2i+1:2i]; 11 player1, 10 player2, 00/01 empty
//   check        start a scan (sampled only when idle and no result is latched)
//   newGame      synchronous clear of results; aborts a scan in progress
//   busy         high while a scan is in progress
//   statusValid  one-cycle pulse when a scan completes
//   gameIsDone   sticky; set on a win or a tie
//   winner       11 player1, 10 player2, 01 tie, 00 none
//   winLine      index of the winning line, 0 unless winner is 11 or 10
module game_status_checker #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic [17:0] gBoard,
  input  logic        check,
  input  logic        newGame,
  output logic        busy,
  output logic        statusValid,
  output logic        gameIsDone,
  output logic [1:0]  winner,
  output logic [2:0]  winLine
);

  typedef enum logic {StIdle, StScan} state_e;

  state_e      state_q;
  logic [17:0] snap_q;
  logic [2:0]  line_idx_q;
  // First winning line seen so far; only used when the full scan is always performed.
  logic        found_q;
  logic [1:0]  found_winner_q;
  logic [2:0]  found_line_q;

  logic [3:0]  idx_a, idx_b, idx_c;
  logic [1:0]  cell_a, cell_b, cell_c;
  logic        line_p1, line_p2, line_win;
  logic [1:0]  line_winner;
  logic        board_full;

  // Cell indices of the line under evaluation.
  always_comb begin
    idx_a = 4'd0;
    idx_b = 4'd1;
    idx_c = 4'd2;
    unique case (line_idx_q)
      3'd0: begin idx_a = 4'd0; idx_b = 4'd1; idx_c = 4'd2; end
      3'd1: begin idx_a = 4'd3; idx_b = 4'd4; idx_c = 4'd5; end
      3'd2: begin idx_a = 4'd6; idx_b = 4'd7; idx_c = 4'd8; end
      3'd3: begin idx_a = 4'd0; idx_b = 4'd3; idx_c = 4'd6; end
      3'd4: begin idx_a = 4'd1; idx_b = 4'd4; idx_c = 4'd7; end
      3'd5: begin idx_a = 4'd2; idx_b = 4'd5; idx_c = 4'd8; end
      3'd6: begin idx_a = 4'd0; idx_b = 4'd4; idx_c = 4'd8; end
      3'd7: begin idx_a = 4'd2; idx_b = 4'd4; idx_c = 4'd6; end
      default: ;
    endcase
  end

  always_comb begin
    cell_a      = snap_q[{idx_a, 1'b0} +: 2];
    cell_b      = snap_q[{idx_b, 1'b0} +: 2];
    cell_c      = snap_q[{idx_c, 1'b0} +: 2];
    line_p1     = (cell_a == 2'b11) && (cell_b == 2'b11) && (cell_c == 2'b11);
    line_p2     = (cell_a == 2'b10) && (cell_b == 2'b10) && (cell_c == 2'b10);
    line_win    = line_p1 | line_p2;
    line_winner = line_p1 ? 2'b11 : 2'b10;
  end

  // Occupied cells (11 or 10) are exactly those with the upper bit set; 01 counts as empty.
  always_comb begin
    board_full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      board_full = board_full & snap_q[2 * i + 1];
    end
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      snap_q         <= '0;
      line_idx_q     <= '0;
      found_q        <= 1'b0;
      found_winner_q <= '0;
      found_line_q   <= '0;
      busy           <= 1'b0;
      statusValid    <= 1'b0;
      gameIsDone     <= 1'b0;
      winner         <= '0;
      winLine        <= '0;
    end else begin
      statusValid <= 1'b0;
      if (newGame) begin
        state_q        <= StIdle;
        line_idx_q     <= '0;
        found_q        <= 1'b0;
        found_winner_q <= '0;
        found_line_q   <= '0;
        busy           <= 1'b0;
        gameIsDone     <= 1'b0;
        winner         <= '0;
        winLine        <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (check && !gameIsDone) begin
              snap_q     <= gBoard;
              line_idx_q <= '0;
              found_q    <= 1'b0;
              busy       <= 1'b1;
              state_q    <= StScan;
            end
          end
          StScan: begin
            if (EARLY_EXIT && line_win) begin
              winner      <= line_winner;
              winLine     <= line_idx_q;
              gameIsDone  <= 1'b1;
              statusValid <= 1'b1;
              busy        <= 1'b0;
              state_q     <= StIdle;
            end else if (line_idx_q == 3'd7) begin
              if (found_q) begin
                winner     <= found_winner_q;
                winLine    <= found_line_q;
                gameIsDone <= 1'b1;
              end else if (line_win) begin
                winner     <= line_winner;
                winLine    <= line_idx_q;
                gameIsDone <= 1'b1;
              end else if (board_full) begin
                winner     <= 2'b01;
                winLine    <= '0;
                gameIsDone <= 1'b1;
              end else begin
                winner  <= 2'b00;
                winLine <= '0;
              end
              statusValid <= 1'b1;
              busy        <= 1'b0;
              state_q     <= StIdle;
            end else begin
              if (line_win && !found_q) begin
                found_q        <= 1'b1;
                found_winner_q <= line_winner;
                found_line_q   <= line_idx_q;
              end
              line_idx_q <= line_idx_q + 3'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_status_checker.sv
module tb_game_status_checker;

  logic        ph1;
  logic        reset;
  logic [17:0] gBoard;
  logic        check;
  logic        newGame;

  logic        busy_ee, sv_ee, done_ee;
  logic [1:0]  winner_ee;
  logic [2:0]  line_ee;
  logic        busy_ne, sv_ne, done_ne;
  logic [1:0]  winner_ne;
  logic [2:0]  line_ne;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] winner;
    logic [2:0] line;
    logic       done;
    int         lat;
  } exp_t;

  exp_t q_ee[$];
  exp_t q_ne[$];

  game_status_checker #(.EARLY_EXIT(1'b1)) dut_ee (
    .ph1(ph1), .reset(reset), .gBoard(gBoard), .check(check), .newGame(newGame),
    .busy(busy_ee), .statusValid(sv_ee), .gameIsDone(done_ee), .winner(winner_ee),
    .winLine(line_ee)
  );

  game_status_checker #(.EARLY_EXIT(1'b0)) dut_ne (
    .ph1(ph1), .reset(reset), .gBoard(gBoard), .check(check), .newGame(newGame),
    .busy(busy_ne), .statusValid(sv_ne), .gameIsDone(done_ne), .winner(winner_ne),
    .winLine(line_ne)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] w, input logic [2:0] l, input logic d,
                          input int lat_ee, input int lat_ne);
    exp_t e;
    e.winner = w; e.line = l; e.done = d; e.lat = lat_ee;
    q_ee.push_back(e);
    e.lat = lat_ne;
    q_ne.push_back(e);
  endtask

  // Cycle i counts from the cycle after the edge that sampled check (i=1 is T+1).
  task automatic sample(input int i);
    exp_t e;
    if (sv_ee) begin
      if (q_ee.size() == 0) begin
        check_eq("spurious_valid_ee", sv_ee, 0);
      end else begin
        e = q_ee.pop_front();
        check_eq("winner_ee", winner_ee, e.winner);
        check_eq("winline_ee", line_ee, e.line);
        check_eq("done_ee", done_ee, e.done);
        check_eq("latency_ee", i, e.lat);
        check_eq("busy_end_ee", busy_ee, 0);
      end
    end
    if (sv_ne) begin
      if (q_ne.size() == 0) begin
        check_eq("spurious_valid_ne", sv_ne, 0);
      end else begin
        e = q_ne.pop_front();
        check_eq("winner_ne", winner_ne, e.winner);
        check_eq("winline_ne", line_ne, e.line);
        check_eq("done_ne", done_ne, e.done);
        check_eq("latency_ne", i, e.lat);
        check_eq("busy_end_ne", busy_ne, 0);
      end
    end
  endtask

  task automatic run_check(input logic [17:0] b, input bit exp_busy, input int ng_at,
                           input int swap_at, input int rst_at, input bit ng_same);
    @(negedge ph1);
    gBoard  = b;
    check   = 1'b1;
    newGame = ng_same;
    @(negedge ph1);
    check   = 1'b0;
    newGame = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (i > 1) @(negedge ph1);
      newGame = (i == ng_at);
      if (i == swap_at) gBoard = 18'h0003F;
      if (i == 1) begin
        check_eq("busy_start_ee", busy_ee, exp_busy);
        check_eq("busy_start_ne", busy_ne, exp_busy);
      end
      if (i == ng_at + 1) begin
        check_eq("abort_busy_ee", busy_ee, 0);
        check_eq("abort_busy_ne", busy_ne, 0);
      end
      if (i == rst_at) begin
        reset = 1'b0;
        #1;
        check_eq("rst_busy_ee", busy_ee, 0);
        check_eq("rst_winner_ee", winner_ee, 0);
        check_eq("rst_done_ee", done_ee, 0);
        check_eq("rst_line_ee", line_ee, 0);
        check_eq("rst_busy_ne", busy_ne, 0);
      end
      sample(i);
    end
    newGame = 1'b0;
    reset   = 1'b1;
    check_eq("pending_ee", q_ee.size(), 0);
    check_eq("pending_ne", q_ne.size(), 0);
    q_ee.delete();
    q_ne.delete();
  endtask

  task automatic new_game();
    @(negedge ph1);
    newGame = 1'b1;
    @(negedge ph1);
    newGame = 1'b0;
    check_eq("ng_winner_ee", winner_ee, 0);
    check_eq("ng_done_ee", done_ee, 0);
    check_eq("ng_winner_ne", winner_ne, 0);
    check_eq("ng_done_ne", done_ne, 0);
  endtask

  initial begin
    reset   = 1'b0;
    gBoard  = '0;
    check   = 1'b0;
    newGame = 1'b0;
    repeat (3) @(negedge ph1);
    check_eq("reset_busy", busy_ee, 0);
    check_eq("reset_valid", sv_ee, 0);
    check_eq("reset_done", done_ee, 0);
    check_eq("reset_winner", winner_ee, 0);
    check_eq("reset_winline", line_ee, 0);
    check_eq("reset_busy_ne", busy_ne, 0);
    reset = 1'b1;

    // Row 0, player1: early exit on line 0.
    push_exp(2'b11, 3'd0, 1'b1, 2, 9);
    run_check(18'h0003F, 1'b1, -1, -1, -1, 1'b0);
    new_game();

    // Anti-diagonal, player2: last line either way.
    push_exp(2'b10, 3'd7, 1'b1, 9, 9);
    run_check(18'h02220, 1'b1, -1, -1, -1, 1'b0);
    new_game();

    // Column 1, player1.
    push_exp(2'b11, 3'd4, 1'b1, 6, 9);
    run_check(18'h0C30C, 1'b1, -1, -1, -1, 1'b0);
    new_game();

    // Both players win (rows 0 and 2): lowest line reported.
    push_exp(2'b11, 3'd0, 1'b1, 2, 9);
    run_check(18'h2A03F, 1'b1, -1, -1, -1, 1'b0);
    new_game();

    // Full board with a win is a win, not a tie.
    push_exp(2'b11, 3'd0, 1'b1, 2, 9);
    run_check(18'h2FEBF, 1'b1, -1, -1, -1, 1'b0);
    new_game();

    // Tie, then a check while done is ignored and outputs hold.
    push_exp(2'b01, 3'd0, 1'b1, 9, 9);
    run_check(18'h3EAFB, 1'b1, -1, -1, -1, 1'b0);
    run_check(18'h0003F, 1'b0, -1, -1, -1, 1'b0);
    check_eq("hold_winner_ee", winner_ee, 2'b01);
    check_eq("hold_done_ee", done_ee, 1);
    check_eq("hold_winner_ne", winner_ne, 2'b01);
    check_eq("hold_done_ne", done_ne, 1);
    new_game();

    // Partial board, no win.
    push_exp(2'b00, 3'd0, 1'b0, 9, 9);
    run_check(18'h0000B, 1'b1, -1, -1, -1, 1'b0);

    // newGame at T+4 aborts the scan.
    run_check(18'h02220, 1'b1, 4, -1, -1, 1'b0);
    check_eq("abort_winner_ee", winner_ee, 0);
    check_eq("abort_winner_ne", winner_ne, 0);

    // newGame and check together: stays idle.
    run_check(18'h0003F, 1'b0, -1, -1, -1, 1'b1);
    check_eq("ngsame_winner", winner_ee, 0);
    check_eq("ngsame_done", done_ee, 0);

    // Board changes mid-scan; the snapshot is used.
    push_exp(2'b00, 3'd0, 1'b0, 9, 9);
    run_check(18'h00000, 1'b1, -1, 2, -1, 1'b0);

    // Async reset mid-scan.
    run_check(18'h02220, 1'b1, -1, -1, 3, 1'b0);
    check_eq("post_rst_winner", winner_ee, 0);
    check_eq("post_rst_done", done_ee, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
